regfile_sb: RTL

Parametrised multi-port register file for the pipelined CPU datapath, replacing the fixed 32x32 two-read/one-write file. Adds asynchronous clear of all storage, byte-strobed writes, a write-to-read bypass that honours the strobes, and a per-register pending scoreboard. Issue logic reserves a destination register; write-back releases it; decode stalls on the busy flags. A registered debug read port serves the board display.

---
 rtl/regfile_sb.sv | 87 ++++++++
 1 files changed

// File: rtl/regfile_sb.sv
// Multi-port register file with byte-strobed writes, strobe-aware write-to-read bypass,
// per-register pending scoreboard and a registered debug read port.
module regfile_sb #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5,
    parameter int STRB_W = DATA_W / 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] ra1,
    input  logic [ADDR_W-1:0] ra2,
    output logic [DATA_W-1:0] rd1,
    output logic [DATA_W-1:0] rd2,
    output logic              busy1,
    output logic              busy2,
    input  logic              rsv_en,
    input  logic [ADDR_W-1:0] rsv_addr,
    input  logic              we,
    input  logic [ADDR_W-1:0] wa,
    input  logic [STRB_W-1:0] wstrb,
    input  logic [DATA_W-1:0] din,
    input  logic [ADDR_W-1:0] dbg_addr,
    output logic [DATA_W-1:0] dbg_data,
    output logic [ADDR_W:0]   pend_cnt
);

    localparam int DEPTH = 2 ** ADDR_W;

    logic [DATA_W-1:0] mem [DEPTH];
    logic [DEPTH-1:0]  pend;
    logic              wr_ok;
    logic              rsv_ok;
    logic              cnt_inc;
    logic              cnt_dec;
    logic [DATA_W-1:0] wr_merged;

    function automatic logic [DATA_W-1:0] merge_bytes(input logic [DATA_W-1:0] old_d,
                                                     input logic [DATA_W-1:0] new_d,
                                                     input logic [STRB_W-1:0] strb);
        logic [DATA_W-1:0] m;
        m = old_d;
        for (int i = 0; i < STRB_W; i++) begin
            if (strb[i]) m[8*i +: 8] = new_d[8*i +: 8];
        end
        return m;
    endfunction

    // Address 0 is never written or reserved, so it stays zero and never pending.
    assign wr_ok     = we && (wa != '0);
    assign rsv_ok    = rsv_en && (rsv_addr != '0);
    assign wr_merged = merge_bytes(mem[wa], din, wstrb);

    assign rd1   = (wr_ok && (wa == ra1)) ? wr_merged : mem[ra1];
    assign rd2   = (wr_ok && (wa == ra2)) ? wr_merged : mem[ra2];
    assign busy1 = pend[ra1] && !(wr_ok && (wa == ra1));
    assign busy2 = pend[ra2] && !(wr_ok && (wa == ra2));

    // A release on the address being reserved in the same cycle is superseded.
    assign cnt_inc = rsv_ok && !pend[rsv_addr];
    assign cnt_dec = wr_ok && pend[wa] && !(rsv_ok && (rsv_addr == wa));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
            pend     <= '0;
            dbg_data <= '0;
            pend_cnt <= '0;
        end else begin
            dbg_data <= mem[dbg_addr];
            if (wr_ok) begin
                mem[wa]  <= wr_merged;
                pend[wa] <= 1'b0;
            end
            if (rsv_ok) begin
                pend[rsv_addr] <= 1'b1;
            end
            if (cnt_inc && !cnt_dec) begin
                pend_cnt <= pend_cnt + (ADDR_W + 1)'(1);
            end else if (cnt_dec && !cnt_inc) begin
                pend_cnt <= pend_cnt - (ADDR_W + 1)'(1);
            end
        end
    end

endmodule
